// File: rtl/canvas_pkg.sv
// Shared constants, state encoding and pixel helpers for the canvas write path.
// Optional feature macro used by this slice: STAMP_PENDING_EN (one-deep stamp queue).
package canvas_pkg;

  localparam int H_RES  = 160;
  localparam int V_RES  = 120;
  localparam int X_W    = 8;
  localparam int Y_W    = 7;
  localparam int ADDR_W = 15;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t CLEAR = 2'd1;
  localparam state_t STAMP = 2'd2;

  localparam logic [8:0] WHITE_RGB = 9'h1FF;

  // Linear framebuffer address, evaluated at full address width so it never wraps.
  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [X_W:0] px,
                                                   input logic [Y_W:0] py);
    pixel_addr = ADDR_W'(py) * ADDR_W'(H_RES) + ADDR_W'(px);
  endfunction

  // True when the (possibly overhanging) pixel lies on the canvas.
  function automatic logic in_canvas(input logic [X_W:0] px, input logic [Y_W:0] py);
    in_canvas = (px < (X_W+1)'(H_RES)) && (py < (Y_W+1)'(V_RES));
  endfunction

endpackage

// File: rtl/brush_scan_counter.sv
// Row-major dx/dy scan counter (dx inner, dy outer) with inclusive limits.
// Serves both the brush stamp scan and the full-canvas raster used by clear.
module brush_scan_counter
  import canvas_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           advance,
  input  logic [X_W-1:0] lim_x,
  input  logic [Y_W-1:0] lim_y,
  output logic [X_W-1:0] nxt_dx,
  output logic [Y_W-1:0] nxt_dy,
  output logic           last
);

  logic [X_W-1:0] dx_q, dx_d;
  logic [Y_W-1:0] dy_q, dy_d;

  // Next-position logic: restart at (0,0), step dx, wrap dx into dy.
  always_comb begin
    dx_d = dx_q;
    dy_d = dy_q;
    if (start) begin
      dx_d = {X_W{1'b0}};
      dy_d = {Y_W{1'b0}};
    end else if (advance) begin
      if (dx_q == lim_x) begin
        dx_d = {X_W{1'b0}};
        if (dy_q == lim_y) begin
          dy_d = {Y_W{1'b0}};
        end else begin
          dy_d = dy_q + {{(Y_W-1){1'b0}}, 1'b1};
        end
      end else begin
        dx_d = dx_q + {{(X_W-1){1'b0}}, 1'b1};
      end
    end else begin
      dx_d = dx_q;
      dy_d = dy_q;
    end
  end

  // Position register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dx_q <= {X_W{1'b0}};
      dy_q <= {Y_W{1'b0}};
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

  assign nxt_dx = dx_d;
  assign nxt_dy = dy_d;
  assign last   = (dx_q == lim_x) && (dy_q == lim_y);

endmodule

// File: rtl/canvas_write_sequencer.sv
// Owns the framebuffer write port; serialises canvas clear and brush stamps,
// one pixel per clock, with registered write outputs.
// Optional feature macro: STAMP_PENDING_EN (stamp requests seen while busy are queued one deep).
module canvas_write_sequencer
  import canvas_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_req,
  input  logic              stamp_req,
  input  logic [X_W-1:0]    stamp_x,
  input  logic [Y_W-1:0]    stamp_y,
  input  logic [1:0]        brush_size,
  input  logic [2:0]        r_in,
  input  logic [2:0]        g_in,
  input  logic [2:0]        b_in,
  output logic              busy,
  output logic              done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_r,
  output logic [2:0]        mem_g,
  output logic [2:0]        mem_b
);

  state_t            state_q, state_d;
  logic [X_W-1:0]    base_x_q, base_x_d;
  logic [Y_W-1:0]    base_y_q, base_y_d;
  logic [1:0]        size_q, size_d;
  logic [8:0]        rgb_q, rgb_d;
  logic              done_q, done_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [8:0]        mem_rgb_q, mem_rgb_d;

  logic              scan_start_s, scan_advance_s, scan_last_s, emit_s;
  logic [X_W-1:0]    lim_x_s, nxt_dx_s;
  logic [Y_W-1:0]    lim_y_s, nxt_dy_s;
  logic [X_W:0]      px_s;
  logic [Y_W:0]      py_s;

  logic              pend_valid_s;
  logic [X_W-1:0]    pend_x_s;
  logic [Y_W-1:0]    pend_y_s;
  logic [1:0]        pend_size_s;
  logic [8:0]        pend_rgb_s;

`ifdef STAMP_PENDING_EN
  logic              pend_valid_q, pend_valid_d;
  logic [X_W-1:0]    pend_x_q, pend_x_d;
  logic [Y_W-1:0]    pend_y_q, pend_y_d;
  logic [1:0]        pend_size_q, pend_size_d;
  logic [8:0]        pend_rgb_q, pend_rgb_d;

  // Pending slot: empties when IDLE starts it (clear not requested), refills from any
  // stamp request that cannot start now (busy, or losing to a simultaneous clear).
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_x_d     = pend_x_q;
    pend_y_d     = pend_y_q;
    pend_size_d  = pend_size_q;
    pend_rgb_d   = pend_rgb_q;
    if ((state_q == IDLE) && !clear_req && pend_valid_q) begin
      pend_valid_d = 1'b0;
    end else begin
      pend_valid_d = pend_valid_q;
    end
    if (stamp_req && ((state_q != IDLE) || clear_req)) begin
      pend_valid_d = 1'b1;
      pend_x_d     = stamp_x;
      pend_y_d     = stamp_y;
      pend_size_d  = brush_size;
      pend_rgb_d   = {r_in, g_in, b_in};
    end else begin
      pend_x_d     = pend_x_q;
    end
  end

  // Pending slot storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_valid_q <= 1'b0;
      pend_x_q     <= {X_W{1'b0}};
      pend_y_q     <= {Y_W{1'b0}};
      pend_size_q  <= 2'd0;
      pend_rgb_q   <= 9'd0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_x_q     <= pend_x_d;
      pend_y_q     <= pend_y_d;
      pend_size_q  <= pend_size_d;
      pend_rgb_q   <= pend_rgb_d;
    end
  end

  assign pend_valid_s = pend_valid_q;
  assign pend_x_s     = pend_x_q;
  assign pend_y_s     = pend_y_q;
  assign pend_size_s  = pend_size_q;
  assign pend_rgb_s   = pend_rgb_q;
`else
  assign pend_valid_s = 1'b0;
  assign pend_x_s     = {X_W{1'b0}};
  assign pend_y_s     = {Y_W{1'b0}};
  assign pend_size_s  = 2'd0;
  assign pend_rgb_s   = 9'd0;
`endif

  // Scan limits: full raster while clearing, brush side otherwise.
  assign lim_x_s = (state_q == CLEAR) ? X_W'(H_RES - 1) : {{(X_W-2){1'b0}}, size_q};
  assign lim_y_s = (state_q == CLEAR) ? Y_W'(V_RES - 1) : {{(Y_W-2){1'b0}}, size_q};

  brush_scan_counter u_scan (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (scan_start_s),
    .advance (scan_advance_s),
    .lim_x   (lim_x_s),
    .lim_y   (lim_y_s),
    .nxt_dx  (nxt_dx_s),
    .nxt_dy  (nxt_dy_s),
    .last    (scan_last_s)
  );

  // Control FSM: accept requests in IDLE (clear > pending stamp > live stamp), then
  // step the scan once per cycle and return to IDLE after the final position.
  always_comb begin
    state_d        = state_q;
    base_x_d       = base_x_q;
    base_y_d       = base_y_q;
    size_d         = size_q;
    rgb_d          = rgb_q;
    done_d         = 1'b0;
    scan_start_s   = 1'b0;
    scan_advance_s = 1'b0;
    emit_s         = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d      = CLEAR;
          base_x_d     = {X_W{1'b0}};
          base_y_d     = {Y_W{1'b0}};
          rgb_d        = WHITE_RGB;
          scan_start_s = 1'b1;
          emit_s       = 1'b1;
        end else if (pend_valid_s) begin
          state_d      = STAMP;
          base_x_d     = pend_x_s;
          base_y_d     = pend_y_s;
          size_d       = pend_size_s;
          rgb_d        = pend_rgb_s;
          scan_start_s = 1'b1;
          emit_s       = 1'b1;
        end else if (stamp_req) begin
          state_d      = STAMP;
          base_x_d     = stamp_x;
          base_y_d     = stamp_y;
          size_d       = brush_size;
          rgb_d        = {r_in, g_in, b_in};
          scan_start_s = 1'b1;
          emit_s       = 1'b1;
        end else begin
          state_d      = IDLE;
        end
      end
      CLEAR, STAMP: begin
        if (scan_last_s) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          scan_advance_s = 1'b1;
          emit_s         = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Absolute coordinate of the pixel going out next; one extra bit so overhang is visible.
  assign px_s = {1'b0, base_x_d} + {1'b0, nxt_dx_s};
  assign py_s = {1'b0, base_y_d} + {1'b0, nxt_dy_s};

  // Write-port staging: on-canvas pixels write, clipped ones spend the cycle idle.
  always_comb begin
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_rgb_d  = mem_rgb_q;
    if (emit_s && in_canvas(px_s, py_s)) begin
      mem_we_d   = 1'b1;
      mem_addr_d = pixel_addr(px_s, py_s);
      mem_rgb_d  = rgb_d;
    end else begin
      mem_we_d   = 1'b0;
    end
  end

  // State, latched operands and registered write-port outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_x_q   <= {X_W{1'b0}};
      base_y_q   <= {Y_W{1'b0}};
      size_q     <= 2'd0;
      rgb_q      <= 9'd0;
      done_q     <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= {ADDR_W{1'b0}};
      mem_rgb_q  <= 9'd0;
    end else begin
      state_q    <= state_d;
      base_x_q   <= base_x_d;
      base_y_q   <= base_y_d;
      size_q     <= size_d;
      rgb_q      <= rgb_d;
      done_q     <= done_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_rgb_q  <= mem_rgb_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_r    = mem_rgb_q[8:6];
  assign mem_g    = mem_rgb_q[5:3];
  assign mem_b    = mem_rgb_q[2:0];

endmodule
